// File: rtl/dcache_init_sweeper_if.sv
// Tag/valid SRAM invalidate-sweep bus: flush request and status toward the controller,
// write request/grant toward the tag SRAM arbiter.
interface dcache_init_sweeper_if #(
  parameter int unsigned IdxW = 8,
  parameter int unsigned Ways = 8
);
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic            init_valid_o;
  logic            req_o;
  logic            gnt_i;
  logic [IdxW-1:0] idx_o;
  logic [Ways-1:0] way_we_o;
  logic            wdata_valid_o;

  modport master (
    input  flush_i, gnt_i,
    output busy_o, done_o, init_valid_o, req_o, idx_o, way_we_o, wdata_valid_o
  );

  modport slave (
    output flush_i, gnt_i,
    input  busy_o, done_o, init_valid_o, req_o, idx_o, way_we_o, wdata_valid_o
  );
endinterface

// File: rtl/dcache_init_sweeper.sv
// D-cache tag/valid invalidate sweeper: clears every way of every set after reset and on flush.
// config_pkg carries the geometry subset of the CVA6 configuration consumed here.
package config_pkg;
  typedef struct packed {
    int unsigned DCACHE_NUM_WORDS;
    int unsigned DCACHE_SET_ASSOC;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{DCACHE_NUM_WORDS: 32'd256, DCACHE_SET_ASSOC: 32'd8};
endpackage

module dcache_init_sweeper #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg      = config_pkg::cva6_cfg_empty,
  parameter bit                    SweepOnReset = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dcache_init_sweeper_if.master bus
);
  localparam int unsigned     NumSets = CVA6Cfg.DCACHE_NUM_WORDS;
  localparam int unsigned     IdxW    = (NumSets > 1) ? $clog2(NumSets) : 1;
  localparam int unsigned     Ways    = CVA6Cfg.DCACHE_SET_ASSOC;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSets - 1);

  typedef enum logic [1:0] {IDLE, ARM, SWEEP, DONE} state_e;

  state_e          state_q;
  logic            busy_q;
  logic            done_q;
  logic            init_valid_q;
  logic            req_q;
  logic [IdxW-1:0] idx_q;
  logic [Ways-1:0] way_we_q;

  // Outputs are registered alongside the state they belong to, so each branch
  // loads the values for the state being entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= SweepOnReset ? ARM : IDLE;
      busy_q       <= SweepOnReset;
      done_q       <= 1'b0;
      init_valid_q <= 1'b0;
      req_q        <= 1'b0;
      idx_q        <= '0;
      way_we_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.flush_i) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
          end
        end
        ARM: begin
          state_q  <= SWEEP;
          idx_q    <= '0;
          req_q    <= 1'b1;
          way_we_q <= '1;
        end
        SWEEP: begin
          if (bus.gnt_i) begin
            // Explicit terminal compare keeps non-power-of-2 set counts correct.
            if (idx_q == LastIdx) begin
              state_q      <= DONE;
              idx_q        <= '0;
              req_q        <= 1'b0;
              way_we_q     <= '0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              init_valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        DONE: begin
          if (bus.flush_i) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          req_q    <= 1'b0;
          way_we_q <= '0;
        end
      endcase
    end
  end

  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.init_valid_o  = init_valid_q;
  assign bus.req_o         = req_q;
  assign bus.idx_o         = idx_q;
  assign bus.way_we_o      = way_we_q;
  assign bus.wdata_valid_o = 1'b0;
endmodule
